// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with ZERO/CARRY/ERR flags and output backpressure.
// Defining ALU_MC_DIV_EN adds the iterative restoring divider for DIV/REM.
module alu_mc #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 2*OPER_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [OPER_WIDTH-1:0] A,
  input  logic [OPER_WIDTH-1:0] B,
  input  logic [3:0]            ALU_FUN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [OUT_WIDTH-1:0]  ALU_OUT,
  output logic                  ZERO,
  output logic                  CARRY,
  output logic                  ERR
);
  localparam int W  = OPER_WIDTH;
  localparam int OW = OUT_WIDTH;

  logic          ready_en_r;
  logic          idle_s;
  logic          accept_s;
  logic          fast_load_s;
  logic          div_load_s;
  logic          load_s;
  logic [W:0]    sum_s;
  logic [W:0]    shl_s;
  logic [W-1:0]  bw_s;
  logic [OW-1:0] fast_res_s;
  logic          fast_carry_s;
  logic          fast_err_s;
  logic [OW-1:0] div_res_s;
  logic          div_err_s;
  logic [OW-1:0] res_s;
  logic          carry_s;
  logic          err_s;

  assign sum_s    = {1'b0, A} + {1'b0, B};
  assign shl_s    = {A, 1'b0};
  assign IN_READY = ready_en_r && idle_s && (!OUT_VALID || OUT_READY);
  assign accept_s = IN_VALID && IN_READY;

  // Holds IN_READY low until the first clock edge after reset release
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Bitwise and shift-right results on OPER_WIDTH bits
  always_comb begin
    bw_s = {W{1'b0}};
    case (ALU_FUN)
      4'h4:    bw_s = A & B;
      4'h5:    bw_s = A | B;
      4'h6:    bw_s = ~(A & B);
      4'h7:    bw_s = ~(A | B);
      4'h8:    bw_s = A ^ B;
      4'h9:    bw_s = ~(A ^ B);
      4'hD:    bw_s = A >> 1'b1;
      default: bw_s = {W{1'b0}};
    endcase
  end

  // Single-cycle result; DIV/REM here only matter when the divider is absent
  always_comb begin
    fast_res_s   = {OW{1'b0}};
    fast_carry_s = 1'b0;
    fast_err_s   = 1'b0;
    case (ALU_FUN)
      4'h0: begin
        fast_res_s   = OW'(sum_s);
        fast_carry_s = sum_s[W];
      end
      4'h1: begin
        fast_res_s   = OW'(A) - OW'(B);
        fast_carry_s = (A < B);
      end
      4'h2:                      fast_res_s = OW'(A) * OW'(B);
      4'h3, 4'hF:                fast_err_s = 1'b1;
      4'h4, 4'h5, 4'h6, 4'h7,
      4'h8, 4'h9, 4'hD:          fast_res_s = OW'(bw_s);
      4'hA: fast_res_s = (A == B) ? OW'(2'd1) : {OW{1'b0}};
      4'hB: fast_res_s = (A > B)  ? OW'(2'd2) : {OW{1'b0}};
      4'hC: fast_res_s = (A < B)  ? OW'(2'd3) : {OW{1'b0}};
      4'hE:                      fast_res_s = OW'(shl_s);
      default:                   fast_res_s = {OW{1'b0}};
    endcase
  end

`ifdef ALU_MC_DIV_EN
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [W-1:0]  quo_r;   // dividend bits shift out MSB-first, quotient bits shift in
  logic [W-1:0]  rem_r;
  logic [W-1:0]  dvs_r;
  logic          is_rem_r;
  logic          dz_r;
  logic          is_div_op_s;
  logic [W:0]    trial_s;
  logic [W:0]    diff_s;
  logic          step_ge_s;

  assign is_div_op_s = (ALU_FUN == 4'h3) || (ALU_FUN == 4'hF);
  assign idle_s      = (state_r == IDLE);
  assign fast_load_s = accept_s && !is_div_op_s;
  assign div_load_s  = (state_r == DIV_DONE) && (!OUT_VALID || OUT_READY);
  assign trial_s     = {rem_r, quo_r[W-1]};
  assign diff_s      = trial_s - {1'b0, dvs_r};
  assign step_ge_s   = (trial_s >= {1'b0, dvs_r});
  assign div_err_s   = dz_r;
  assign div_res_s   = is_rem_r ? OW'(rem_r) : (dz_r ? {OW{1'b1}} : OW'(quo_r));

  // Divider state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Divider next-state logic; zero divisor skips the iterations
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && is_div_op_s) begin
          state_s = (B == {W{1'b0}}) ? DIV_DONE : DIV_BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      DIV_BUSY: begin
        if (cnt_r == CW'(W-1)) begin
          state_s = DIV_DONE;
        end else begin
          state_s = DIV_BUSY;
        end
      end
      DIV_DONE: begin
        if (!OUT_VALID || OUT_READY) begin
          state_s = IDLE;
        end else begin
          state_s = DIV_DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture and one restoring step per busy cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r    <= {CW{1'b0}};
      quo_r    <= {W{1'b0}};
      rem_r    <= {W{1'b0}};
      dvs_r    <= {W{1'b0}};
      is_rem_r <= 1'b0;
      dz_r     <= 1'b0;
    end else if (idle_s && accept_s && is_div_op_s) begin
      cnt_r    <= {CW{1'b0}};
      quo_r    <= A;
      rem_r    <= (B == {W{1'b0}}) ? A : {W{1'b0}};
      dvs_r    <= B;
      is_rem_r <= (ALU_FUN == 4'hF);
      dz_r     <= (B == {W{1'b0}});
    end else if (state_r == DIV_BUSY) begin
      cnt_r <= cnt_r + CW'(1);
      quo_r <= {quo_r[W-2:0], step_ge_s};
      rem_r <= step_ge_s ? diff_s[W-1:0] : trial_s[W-1:0];
    end
  end
`else
  assign idle_s      = 1'b1;
  assign fast_load_s = accept_s;
  assign div_load_s  = 1'b0;
  assign div_res_s   = {OW{1'b0}};
  assign div_err_s   = 1'b0;
`endif

  // Selects which result, if any, loads into the output register
  always_comb begin
    res_s   = fast_res_s;
    carry_s = fast_carry_s;
    err_s   = fast_err_s;
    load_s  = 1'b0;
    if (div_load_s) begin
      res_s   = div_res_s;
      carry_s = 1'b0;
      err_s   = div_err_s;
      load_s  = 1'b1;
    end else begin
      load_s  = fast_load_s;
    end
  end

  // Output register: loads a new result or retires the held one
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OUT_VALID <= 1'b0;
      ALU_OUT   <= {OW{1'b0}};
      ZERO      <= 1'b0;
      CARRY     <= 1'b0;
      ERR       <= 1'b0;
    end else if (load_s) begin
      OUT_VALID <= 1'b1;
      ALU_OUT   <= res_s;
      ZERO      <= (res_s == {OW{1'b0}});
      CARRY     <= carry_s;
      ERR       <= err_s;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and random stimulus for alu_mc, checked every cycle
// against a transaction-level reference model (honours ALU_MC_DIV_EN).
module tb_alu_mc;
  localparam int W  = 8;
  localparam int OW = 2*W;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IN_VALID;
  logic          IN_READY;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [3:0]    ALU_FUN;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [OW-1:0] ALU_OUT;
  logic          ZERO;
  logic          CARRY;
  logic          ERR;

  always #5 CLK = ~CLK;

  alu_mc #(.OPER_WIDTH(W), .OUT_WIDTH(OW)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .ALU_OUT(ALU_OUT), .ZERO(ZERO),
    .CARRY(CARRY), .ERR(ERR)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: one shown result, at most one pending result
  bit            ready_en   = 1'b0;
  bit            exp_ov     = 1'b0;
  bit            pend_valid = 1'b0;
  bit            last_acc   = 1'b0;
  int            pend_cnt   = 0;
  logic [OW-1:0] exp_res    = '0;
  logic          exp_c      = 1'b0;
  logic          exp_e      = 1'b0;
  logic [OW-1:0] pend_res   = '0;
  logic          pend_c     = 1'b0;
  logic          pend_e     = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_model(input int f, input longint a, input longint b,
                                    output logic [OW-1:0] r, output logic c, output logic e);
    longint m;
    longint v;
    m = (64'd1 << W) - 64'd1;
    v = 0;
    c = 1'b0;
    e = 1'b0;
    case (f)
      0:  begin v = a + b; c = (v > m); end
      1:  begin v = a - b; c = (a < b); end
      2:  v = a * b;
`ifdef ALU_MC_DIV_EN
      3:  begin if (b == 0) begin v = -1; e = 1'b1; end else v = a / b; end
      15: begin if (b == 0) begin v = a;  e = 1'b1; end else v = a % b; end
`else
      3, 15: begin v = 0; e = 1'b1; end
`endif
      4:  v = a & b;
      5:  v = a | b;
      6:  v = (~(a & b)) & m;
      7:  v = (~(a | b)) & m;
      8:  v = a ^ b;
      9:  v = (~(a ^ b)) & m;
      10: v = (a == b) ? 1 : 0;
      11: v = (a > b) ? 2 : 0;
      12: v = (a < b) ? 3 : 0;
      13: v = a / 2;
      14: v = a * 2;
      default: v = 0;
    endcase
    r = v[OW-1:0];
  endfunction

  // Edges from the accept edge to the edge that loads the result
  function automatic int ref_delay(input int f, input longint b);
`ifdef ALU_MC_DIV_EN
    if (f == 3 || f == 15) return (b == 0) ? 1 : W + 1;
`endif
    return 0;
  endfunction

  task automatic tick();
    bit            exp_ready;
    bit            acc;
    bit            ret;
    bit            due;
    logic [OW-1:0] r;
    logic          c;
    logic          e;
    int            d;
    @(negedge CLK);
    exp_ready = ready_en && !pend_valid && (!exp_ov || OUT_READY);
    check("in_ready", IN_READY, exp_ready);
    check("out_valid", OUT_VALID, exp_ov);
    if (exp_ov) begin
      check("alu_out", ALU_OUT, exp_res);
      check("zero", ZERO, exp_res == {OW{1'b0}});
      check("carry", CARRY, exp_c);
      check("err", ERR, exp_e);
    end
    acc = IN_VALID && exp_ready && RST;
    ret = exp_ov && OUT_READY;
    due = pend_valid && (pend_cnt == 1) && (!exp_ov || OUT_READY);
    ref_model(int'(ALU_FUN), longint'(A), longint'(B), r, c, e);
    d = ref_delay(int'(ALU_FUN), longint'(B));
    @(posedge CLK);
    #1;
    last_acc = acc;
    if (RST) ready_en = 1'b1;
    if (ret) exp_ov = 1'b0;
    if (due) begin
      exp_ov = 1'b1; exp_res = pend_res; exp_c = pend_c; exp_e = pend_e;
      pend_valid = 1'b0;
    end else if (pend_valid && pend_cnt > 1) begin
      pend_cnt--;
    end
    if (acc) begin
      if (d == 0) begin
        exp_ov = 1'b1; exp_res = r; exp_c = c; exp_e = e;
      end else begin
        pend_valid = 1'b1; pend_cnt = d; pend_res = r; pend_c = c; pend_e = e;
      end
    end
  endtask

  task automatic send(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    IN_VALID = 1'b1; ALU_FUN = f; A = a; B = b;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 40);
    check("accept", {63'd0, last_acc}, 64'd1);
    IN_VALID = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", IN_READY, 1'b0);
    check("rst_out_valid", OUT_VALID, 1'b0);
    check("rst_alu_out", ALU_OUT, {OW{1'b0}});
    check("rst_flags", {ZERO, CARRY, ERR}, 3'b000);
  endtask

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0:       return {W{1'b0}};
      1:       return {W{1'b1}};
      2:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    RST = 1'b0; IN_VALID = 1'b0; A = '0; B = '0; ALU_FUN = 4'h0; OUT_READY = 1'b1;
    ticks(3);
    check_reset_outputs();
    RST = 1'b1;

    send(4'h0, 8'hFF, 8'h01);
    tick();

    OUT_READY = 1'b0;
    send(4'h1, 8'd3, 8'd5);
    IN_VALID = 1'b1; ALU_FUN = 4'h0; A = 8'd1; B = 8'd1;
    ticks(3);
    OUT_READY = 1'b1;
    send(4'h0, 8'd1, 8'd1);

    send(4'h2, 8'hFF, 8'hFF);
    send(4'hA, 8'd7, 8'd7);
    ticks(2);

    send(4'h3, 8'd200, 8'd7);
    ticks(12);
    send(4'hF, 8'd200, 8'd7);
    ticks(12);
    send(4'h3, 8'd9, 8'd0);
    ticks(3);
    send(4'hF, 8'd9, 8'd0);
    ticks(3);

    // Reset in the middle of a division
    send(4'h3, 8'd200, 8'd7);
    ticks(4);
    RST = 1'b0;
    #1;
    check_reset_outputs();
    exp_ov = 1'b0; pend_valid = 1'b0; ready_en = 1'b0;
    ticks(2);
    RST = 1'b1;
    ticks(12);

    for (int i = 0; i < 600; i++) begin
      if (!IN_VALID || last_acc) begin
        if ($urandom_range(0, 3) != 0) begin
          IN_VALID = 1'b1;
          ALU_FUN  = 4'($urandom_range(0, 15));
          A        = rand_opnd();
          B        = ($urandom_range(0, 5) == 0) ? A : rand_opnd();
        end else begin
          IN_VALID = 1'b0;
        end
      end
      OUT_READY = ($urandom_range(0, 3) != 0);
      tick();
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    ticks(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
